note_glyph_renderer: RTL and testbench

NOTE_GLYPH_RENDERER -- requirements
Module: note_glyph_renderer

---
 rtl/note_glyph_renderer.sv | 122 ++++++++++++
 tb/tb_note_glyph_renderer.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/note_glyph_renderer.sv
// note_glyph_renderer: draws a string of bitmap glyphs or clears the whole frame, one pixel per clock
//   clk, reset (async, active-high)         clock and reset
//   start, mode                             request pulse; mode 0 = draw glyph string, 1 = clear screen
//   glyphs, x, y, fg_colour, bg_colour      request operands, latched when start is accepted in IDLE
//   x_out, y_out, colour, writeEn           registered pixel write port
//   busy, done                              busy outside IDLE; done pulses once when a request completes
//   GLYPH_BG_FILL_EN                        when defined, clear glyph bits are written in bg_colour
module note_glyph_renderer #(
  parameter int GLYPH_W = 12,
  parameter int GLYPH_H = 12,
  parameter int NUM_GLYPHS = 3,
  parameter int GLYPH_GAP = 0,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int X_W = 8,
  parameter int Y_W = 7
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic                                  mode,
  input  logic [NUM_GLYPHS*GLYPH_W*GLYPH_H-1:0] glyphs,
  input  logic [X_W-1:0]                        x,
  input  logic [Y_W-1:0]                        y,
  input  logic [2:0]                            fg_colour,
  input  logic [2:0]                            bg_colour,
  output logic [X_W-1:0]                        x_out,
  output logic [Y_W-1:0]                        y_out,
  output logic [2:0]                            colour,
  output logic                                  writeEn,
  output logic                                  busy,
  output logic                                  done
);
  localparam int TOTAL = NUM_GLYPHS * GLYPH_W * GLYPH_H;
  localparam int PW = $clog2(TOTAL + 1);
  localparam logic [X_W:0] SW = (X_W + 1)'(SCREEN_W);
  localparam logic [Y_W:0] SH = (Y_W + 1)'(SCREEN_H);
  localparam logic [X_W:0] STEP = (X_W + 1)'(GLYPH_W + GLYPH_GAP);
`ifdef GLYPH_BG_FILL_EN
  localparam logic FILL = 1'b1;
`else
  localparam logic FILL = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, DRAW, CLEAR, FINISH} state_t;
  state_t state, state_n;
  logic [TOTAL-1:0] bits;
  logic [X_W-1:0] x0, cx;
  logic [Y_W-1:0] y0, cy;
  logic [2:0] fg, bg;
  logic [X_W:0] gx, wx;
  logic [Y_W:0] wy;
  logic [PW-1:0] p;
  logic in_screen, last_gc, last_gr, last_draw, last_sc, last_sr;
  always_comb begin
    wx = {1'b0, x0} + gx + {1'b0, cx};
    wy = {1'b0, y0} + {1'b0, cy};
    in_screen = (wx < SW) && (wy < SH);
    last_gc = cx == X_W'(GLYPH_W - 1);
    last_gr = cy == Y_W'(GLYPH_H - 1);
    last_draw = p == PW'(TOTAL - 1);
    last_sc = cx == X_W'(SCREEN_W - 1);
    last_sr = cy == Y_W'(SCREEN_H - 1);
    state_n = state == IDLE   ? (start ? (mode ? CLEAR : DRAW) : IDLE) :
              state == DRAW   ? (last_draw ? FINISH : DRAW) :
              state == CLEAR  ? (last_sc && last_sr ? FINISH : CLEAR) : IDLE;
    busy = state != IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      bits <= '0;
      x0 <= '0;
      y0 <= '0;
      fg <= '0;
      bg <= '0;
      gx <= '0;
      cx <= '0;
      cy <= '0;
      p <= '0;
      x_out <= '0;
      y_out <= '0;
      colour <= '0;
      writeEn <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      done <= state == FINISH;
      writeEn <= 1'b0;
      if (state == IDLE && start) begin
        bits <= glyphs;
        x0 <= x;
        y0 <= y;
        fg <= fg_colour;
        bg <= bg_colour;
        gx <= '0;
        cx <= '0;
        cy <= '0;
        p <= '0;
      end
      // the bitmap shifts left each pixel so the current glyph bit is always the MSB
      if (state == DRAW) begin
        x_out <= wx[X_W-1:0];
        y_out <= wy[Y_W-1:0];
        colour <= bits[TOTAL-1] ? fg : bg;
        writeEn <= in_screen && (bits[TOTAL-1] || FILL);
        bits <= bits << 1;
        p <= p + 1'b1;
        cx <= last_gc ? '0 : cx + 1'b1;
        cy <= last_gc ? (last_gr ? '0 : cy + 1'b1) : cy;
        gx <= (last_gc && last_gr) ? gx + STEP : gx;
      end
      if (state == CLEAR) begin
        x_out <= cx;
        y_out <= cy;
        colour <= bg;
        writeEn <= 1'b1;
        cx <= last_sc ? '0 : cx + 1'b1;
        cy <= last_sc ? (last_sr ? '0 : cy + 1'b1) : cy;
      end
    end
  end
endmodule

// File: tb/tb_note_glyph_renderer.sv
// tb_note_glyph_renderer: scoreboard bench for note_glyph_renderer
module tb_note_glyph_renderer;
  localparam int T = 432;
`ifdef GLYPH_BG_FILL_EN
  localparam bit FILL = 1'b1;
`else
  localparam bit FILL = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, mode = 1'b0;
  logic [T-1:0] glyphs = '0;
  logic [7:0] x = '0;
  logic [6:0] y = '0;
  logic [2:0] fg_colour = '0, bg_colour = '0;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour;
  logic writeEn, busy, done;
  int n_chk = 0, n_fail = 0;
  logic [18:0] q[$];
  note_glyph_renderer dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .glyphs(glyphs),
    .x(x), .y(y), .fg_colour(fg_colour), .bg_colour(bg_colour),
    .x_out(x_out), .y_out(y_out), .colour(colour), .writeEn(writeEn),
    .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    logic [18:0] e;
    if (!reset) begin
      if (writeEn) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL pixel: got write (%0d,%0d,%0d) expected none", x_out, y_out, colour);
        end else begin
          e = q.pop_front();
          chk("pixel {k,x,y,c}", {13'd0, 1'b0, x_out, y_out, colour}, {13'd0, e});
        end
      end
      if (done) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL done: got done pulse expected none");
        end else begin
          e = q.pop_front();
          chk("done marker", {13'd0, done, 18'd0}, {13'd0, e[18] ? {1'b1, 18'd0} : e});
        end
      end
    end
  end
  task automatic push_draw(input logic [T-1:0] gl, input int xi, input int yi, input logic [2:0] f, input logic [2:0] b);
    for (int g = 0; g < 3; g++)
      for (int r = 0; r < 12; r++)
        for (int c = 0; c < 12; c++) begin
          logic bt;
          int wx, wy;
          bt = gl[T-1-(g*144+r*12+c)];
          wx = xi + g*12 + c;
          wy = yi + r;
          if ((bt || FILL) && wx < 160 && wy < 120)
            q.push_back({1'b0, 8'(wx), 7'(wy), bt ? f : b});
        end
    q.push_back({1'b1, 18'd0});
  endtask
  task automatic push_clear(input logic [2:0] b, input int n, input bit with_done);
    for (int i = 0; i < n; i++) q.push_back({1'b0, 8'(i % 160), 7'(i / 160), b});
    if (with_done) q.push_back({1'b1, 18'd0});
  endtask
  task automatic run(input logic m, input logic [T-1:0] gl, input logic [7:0] xi, input logic [6:0] yi,
                     input logic [2:0] f, input logic [2:0] b, input int exp_cyc, input int restart_at);
    int cnt = 0;
    mode = m; glyphs = gl; x = xi; y = yi; fg_colour = f; bg_colour = b; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("busy after start", {31'd0, busy}, 32'd1);
    while (!done && cnt < 25000) begin
      @(posedge clk); #1 cnt++;
      if (cnt == restart_at) begin
        start = 1'b1; mode = ~m; x = xi + 8'd3; glyphs = ~gl; fg_colour = ~f; bg_colour = ~b;
      end
      if (cnt == restart_at + 1) start = 1'b0;
    end
    chk("cycles start to done", cnt, exp_cyc);
    chk("busy with done", {31'd0, busy}, 32'd0);
  endtask
  initial begin
    logic [T-1:0] ones, one_bit, last_bit;
    ones = '1;
    one_bit = '0;
    one_bit[T-1] = 1'b1;
    last_bit = '0;
    last_bit[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset writeEn", {31'd0, writeEn}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset x_out", {24'd0, x_out}, 32'd0);
    chk("reset y_out", {25'd0, y_out}, 32'd0);
    chk("reset colour", {29'd0, colour}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    push_draw(ones, 10, 20, 3'd5, 3'd0);
    run(1'b0, ones, 8'd10, 7'd20, 3'd5, 3'd0, 433, 100);
    @(negedge clk);
    push_draw(ones, 150, 115, 3'd3, 3'd1);
    run(1'b0, ones, 8'd150, 7'd115, 3'd3, 3'd1, 433, 0);
    @(negedge clk);
    push_draw(one_bit, 30, 40, 3'd6, 3'd2);
    run(1'b0, one_bit, 8'd30, 7'd40, 3'd6, 3'd2, 433, 50);
    @(negedge clk);
    push_clear(3'd0, 19200, 1'b1);
    run(1'b1, '0, 8'd0, 7'd0, 3'd0, 3'd0, 19201, 0);
    @(negedge clk);
    push_clear(3'd7, 100, 1'b0);
    mode = 1'b1; bg_colour = 3'd7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("mid-clear reset writeEn", {31'd0, writeEn}, 32'd0);
    chk("mid-clear reset busy", {31'd0, busy}, 32'd0);
    chk("mid-clear reset x_out", {24'd0, x_out}, 32'd0);
    chk("mid-clear reset colour", {29'd0, colour}, 32'd0);
    chk("pixels before reset", q.size(), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    push_draw(last_bit, 0, 0, 3'd4, 3'd1);
    run(1'b0, last_bit, 8'd0, 7'd0, 3'd4, 3'd1, 433, 0);
    @(negedge clk);
    #1;
    chk("scoreboard drained", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
